// File: rtl/output_port_arbiter.sv
// Round-robin output-port scheduler for one router direction.
// Grants one requesting input block per packet, keeps the grant until the
// tail flit has been transferred, and then streams flits from that input's
// FIFO to the neighbour router under full/ret back-pressure.
module output_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 5,
  parameter int PTR_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            req,
  input  logic [N_IN-1:0]            last,
  input  logic [N_IN*DATA_WIDTH-1:0] data_in,
  input  logic                       ret_in,
  output logic [N_IN-1:0]            pop,
  output logic [N_IN-1:0]            gnt,
  output logic                       val_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [N_IN-1:0]         gnt_q, gnt_d;
  logic [PTR_W-1:0]        gidx_q, gidx_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    val_q, val_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [PTR_W-1:0]        start_idx;
  logic                    arb_found;
  logic [PTR_W-1:0]        arb_idx;
  logic                    xfer;
  logic                    tail;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Round-robin search: lowest requester at or above the pointer wins,
  // otherwise the lowest requester overall (the wrap-around case).
  always_comb begin
    logic             hi_found;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    arb_found = 1'b0;
    // An out-of-range pointer can only come from a forced value; treat it as 0.
    start_idx = ({1'b0, ptr_q} < (PTR_W+1)'(N_IN)) ? ptr_q : '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (req[i]) begin
        arb_found = 1'b1;
        lo_idx    = PTR_W'(i);
        if (PTR_W'(i) >= start_idx) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
      end
    end
    arb_idx = hi_found ? hi_idx : lo_idx;
  end

  // Transfer qualification and head-flit mux for the granted input; the
  // grant is one-hot, so masking with it keeps pop one-hot as well.
  always_comb begin
    xfer     = (state_q == BUSY) && ((gnt_q & req) != '0) && !ret_in;
    tail     = (gnt_q & last) != '0;
    pop      = xfer ? gnt_q : '0;
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_q[i]) begin
        sel_data = sel_data | data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, stream and watch for the tail in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    val_d   = xfer;
    data_d  = xfer ? sel_data : data_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = BUSY;
          gnt_d   = N_IN'(1) << arb_idx;
          gidx_d  = arb_idx;
        end
      end
      BUSY: begin
        if (xfer && tail) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == PTR_W'(N_IN - 1)) ? '0 : gidx_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      val_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      data_q  <= data_d;
    end
  end

  assign gnt      = gnt_q;
  assign val_out  = val_q;
  assign data_out = data_q;
  assign busy     = (state_q == BUSY);

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Round-robin scheduler for one router output port. It shares the port between N_IN input blocks.
- Each input block raises a request when its head packet is routed to this port. The arbiter grants one requester and holds that grant until the tail flit has passed. It then pops flits from the granted input FIFO and drives them to the neighbour router, respecting the neighbour's full/ret back-pressure.
- One instance is placed per output direction, between the input blocks and the crossbar/link.

Parameters:
- DATA_WIDTH, 8: flit width in bits.
- N_IN, 5: number of requesting input blocks (N, E, S, W, local).
- PTR_W, 3: width of the round-robin pointer; must satisfy 2^PTR_W >= N_IN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_IN  req[i]=1: input i has a flit ready for this port.
- last  input  N_IN  last[i]=1: the flit currently at the head of input i is the packet tail.
- data_in  input  N_IN*DATA_WIDTH  head flits, input i on bits [i*DATA_WIDTH +: DATA_WIDTH].
- ret_in  input  1  downstream buffer full; 1 = stall.
- pop  output  N_IN  one-hot read strobe to input i's FIFO; combinational.
- gnt  output  N_IN  one-hot registered grant (all zero when idle).
- val_out  output  1  registered flit-valid to downstream.
- data_out  output  DATA_WIDTH  registered flit to downstream.
- busy  output  1  1 while a packet owns the port.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gnt=0, ptr=0, val_out=0, data_out=0, busy=0.
  - pop is 0 whenever state is IDLE, so it is also 0 during reset.
  - Reset mid-packet abandons the packet. No further pop occurs, and the input block is responsible for its own flush.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE:
  - If req is nonzero, select the first i with req[i]=1, searching from ptr upward with wrap at N_IN-1 to 0.
  - Next edge: gnt <= onehot(i), state <= BUSY.
  - No pop is issued in IDLE, so arbitration costs exactly 1 cycle.
- BUSY, with g = granted index:
  - Transfer condition: xfer = req[g] & ~ret_in.
  - pop[g] = xfer, combinational in the same cycle.
  - On an xfer edge: data_out <= data_in[g], val_out <= 1.
  - On a non-xfer edge: val_out <= 0 and data_out holds its value.
- Packet completion:
  - If xfer & last[g]: next edge state <= IDLE, gnt <= 0, ptr <= (g+1) mod N_IN.
  - The tail flit appears on val_out/data_out one cycle after its pop.
- Latency: first flit reaches val_out 2 cycles after req rises, given an idle port and ret_in=0. After that, throughput is 1 flit/cycle.
- Requester drops req mid-packet (FIFO empty): the grant is held, bubbles are sent (val_out=0), and nothing is popped. The port is never re-arbitrated mid-packet.
- ret_in=1: pop=0 and val_out=0 on the next edge. Grant and ptr are unchanged.
- Requests from non-granted inputs are ignored in BUSY.
- ptr advances only on packet completion, never on grant.
- ptr values >= N_IN are unreachable. If forced there, the next arbitration treats ptr as 0.
- Single-flit packet (last=1 on first flit): BUSY for exactly 1 cycle when not stalled.
- req/last bits for indices >= N_IN do not exist. The arbiter must never drive two pop bits in the same cycle.

Test Plan:
1. Reset state: hold rst=0 with random req -> gnt=0, pop=0, val_out=0, data_out=0, busy=0. Release rst and raise req=5'b00100 -> gnt=5'b00100 after 1 edge, and data_in[2] appears on data_out with val_out=1 two edges after req.
2. Round-robin order: req=5'b11111 continuously, each packet 1 flit (last=all 1) -> grants in order 0,1,2,3,4,0. Each grant is a 2-cycle IDLE/BUSY pair; ptr ends at 1.
3. Packet hold: input 1 sends a 3-flit packet (A1, A2, A3) while req[3]=1 -> gnt stays 5'b00010 for 3 transfers, and data_out sequence is A1, A2, A3. gnt then moves to 5'b01000.
4. Back-pressure: ret_in=1 for 4 cycles mid-packet -> pop=0 and val_out=0 during the stall, no flit is lost or duplicated, and the flow resumes the cycle after ret_in=0.
5. Bubble: the granted input drops req for 2 cycles mid-packet while input 4 requests -> grant is not transferred, val_out=0 for 2 cycles, and the packet then completes.
6. Mid-packet reset: assert rst=0 during flit 2 of 4 -> all outputs clear immediately. After release, ptr=0 and the next arbitration starts from input 0.
